// File: rtl/plot_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : plot_scheduler_pkg
// Description : Shared constants for the plot scheduler: slot indices, slot
//               colours, packed-position field widths and a mod-5 slot adder.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package plot_scheduler_pkg;

  localparam int X_W         = 8;
  localparam int Y_W         = 7;
  localparam int POS_W       = X_W + Y_W;
  localparam int NUM_PLAYERS = 4;
  localparam int NUM_SLOTS   = NUM_PLAYERS + 1;

  localparam logic [2:0] SLOT_P0    = 3'd0;
  localparam logic [2:0] SLOT_P1    = 3'd1;
  localparam logic [2:0] SLOT_P2    = 3'd2;
  localparam logic [2:0] SLOT_P3    = 3'd3;
  localparam logic [2:0] SLOT_TIMER = 3'd4;

  localparam logic [2:0] COLOUR_P0    = 3'b001;
  localparam logic [2:0] COLOUR_P1    = 3'b010;
  localparam logic [2:0] COLOUR_P2    = 3'b100;
  localparam logic [2:0] COLOUR_P3    = 3'b110;
  localparam logic [2:0] COLOUR_TIMER = 3'b111;

  function automatic logic [2:0] slot_colour(input logic [2:0] slot);
    case (slot)
      SLOT_P0: return COLOUR_P0;
      SLOT_P1: return COLOUR_P1;
      SLOT_P2: return COLOUR_P2;
      SLOT_P3: return COLOUR_P3;
      default: return COLOUR_TIMER;
    endcase
  endfunction

  // (a + b) mod 5 for operands in 0..4; the sum never exceeds 8, so one
  // conditional subtraction is enough.
  function automatic logic [2:0] slot_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] sum;
    logic [3:0] wrapped;
    sum     = {1'b0, a} + {1'b0, b};
    wrapped = (sum >= 4'd5) ? (sum - 4'd5) : sum;
    return wrapped[2:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/plot_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : plot_scheduler_if
// Description : Player request bus shared by the four movement streams and
//               the plot scheduler.
// Signals     : p_req[4]  level request per player, held until granted
//               p_pos[60] packed {x[7:0], y[6:0]} per player, player i at
//                         [15i+14:15i]
//               p_gnt[4]  one-hot single-cycle grant
// Modports    : master (players), slave (scheduler)
// Revision    : 1.0 - initial release
// ============================================================================
interface plot_scheduler_if;
  import plot_scheduler_pkg::*;

  logic [NUM_PLAYERS-1:0]       p_req;
  logic [NUM_PLAYERS*POS_W-1:0] p_pos;
  logic [NUM_PLAYERS-1:0]       p_gnt;

  modport master (output p_req, output p_pos, input p_gnt);
  modport slave  (input p_req, input p_pos, output p_gnt);

endinterface
`default_nettype wire

// File: rtl/plot_scheduler_rr_arbiter5.sv
`default_nettype none
// ============================================================================
// Module      : plot_scheduler_rr_arbiter5
// Description : Combinational 5-slot round-robin arbiter. Searches from ptr
//               upward, wrapping mod 5, and grants the first eligible slot.
// Ports       : eligible[5]  slot eligibility
//               ptr[3]       first slot in search order (0..4)
//               grant[5]     one-hot grant
//               grant_idx[3] index of the granted slot
//               grant_valid  any slot granted
//               next_ptr[3]  slot after the granted one, or ptr if none
// Revision    : 1.0 - initial release
// ============================================================================
module plot_scheduler_rr_arbiter5
  import plot_scheduler_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] eligible,
  input  logic [2:0]           ptr,
  output logic [NUM_SLOTS-1:0] grant,
  output logic [2:0]           grant_idx,
  output logic                 grant_valid,
  output logic [2:0]           next_ptr
);

  logic [2:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    next_ptr    = ptr;
    cand        = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      cand = slot_add(ptr, 3'(k));
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
        next_ptr    = slot_add(cand, 3'd1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/plot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : plot_scheduler
// Description : Shares the VGA pixel-write port between four player streams
//               and the countdown timer bar, and owns the game running flag.
// Ports       : CLOCK_50      system clock
//               resetn        asynchronous active-low reset
//               start         pulse, (re)starts a round
//               tick_en       rate-divider pulse, advances the bar
//               bus           player request bus (slave side)
//               plot/x/y/colour  registered write to vga_adapter
//               running       game active
//               timer_x       next bar column to draw
// Revision    : 1.0 - initial release
// ============================================================================
module plot_scheduler
  import plot_scheduler_pkg::*;
#(
  parameter logic [Y_W-1:0] TIMER_ROW    = 7'd119,
  parameter logic [X_W-1:0] TIMER_LAST_X = 8'd158
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                start,
  input  logic                tick_en,
  plot_scheduler_if.slave     bus,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [2:0]          colour,
  output logic                running,
  output logic [X_W-1:0]      timer_x
);

  logic                 timer_pend;
  logic [2:0]           rr_ptr;
  logic [NUM_SLOTS-1:0] eligible;
  logic [NUM_SLOTS-1:0] arb_grant;
  logic [2:0]           arb_idx;
  logic                 arb_valid;
  logic [2:0]           arb_next;
  logic [POS_W-1:0]     sel_pos;
  logic                 timer_granted;

  // A start cycle issues no grant at all, including a pending timer slot.
  assign eligible = start ? '0
                          : {timer_pend, bus.p_req & {NUM_PLAYERS{running}}};

  plot_scheduler_rr_arbiter5 u_arb (
    .eligible    (eligible),
    .ptr         (rr_ptr),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid),
    .next_ptr    (arb_next)
  );

  assign bus.p_gnt     = arb_grant[NUM_PLAYERS-1:0];
  assign timer_granted = arb_grant[SLOT_TIMER];

  always_comb begin
    sel_pos = {timer_x, TIMER_ROW};
    case (arb_idx)
      SLOT_P0: sel_pos = bus.p_pos[0*POS_W +: POS_W];
      SLOT_P1: sel_pos = bus.p_pos[1*POS_W +: POS_W];
      SLOT_P2: sel_pos = bus.p_pos[2*POS_W +: POS_W];
      SLOT_P3: sel_pos = bus.p_pos[3*POS_W +: POS_W];
      default: sel_pos = {timer_x, TIMER_ROW};
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      plot       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      running    <= 1'b0;
      timer_x    <= '0;
      timer_pend <= 1'b0;
      rr_ptr     <= '0;
    end else if (start) begin
      // Any tick arriving with start is dropped.
      plot       <= 1'b0;
      running    <= 1'b1;
      timer_x    <= '0;
      timer_pend <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      plot <= arb_valid;
      if (arb_valid) begin
        rr_ptr <= arb_next;
        x      <= sel_pos[POS_W-1:Y_W];
        y      <= sel_pos[Y_W-1:0];
        colour <= slot_colour(arb_idx);
      end
      if (timer_granted) begin
        timer_pend <= 1'b0;
        if (timer_x == TIMER_LAST_X) begin
          running <= 1'b0;
        end else begin
          timer_x <= timer_x + 8'd1;
        end
      end else if (tick_en && running) begin
        // Setting an already-set flag is the "dropped tick" behaviour.
        timer_pend <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/plot_scheduler.md
Name: plot_scheduler

Overview:
Shares the single VGA adapter pixel-write port between four player position streams and the on-screen countdown bar. Uses a registered 5-slot round-robin arbiter: slots 0-3 are players, slot 4 is the internal timer bar. Also owns the game `running` flag, which stops when the bar reaches the right edge. Sits between the movement logic/rate divider and vga_adapter, in place of a fixed free-running draw sequence.

Parameters:
TIMER_ROW, 119, y coordinate of the timer bar row (7 bits).
TIMER_LAST_X, 158, last bar x plotted; plotting it ends the game.

Ports:
CLOCK_50  in  1  system clock; all state on its rising edge.
resetn  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; (re)starts a round.
tick_en  in  1  one-cycle enable from the rate divider; advances the bar.
p_req  in  4  per-player plot request, level; held until granted.
p_pos  in  60  packed positions, player i at [15i+14:15i]; {x[7:0], y[6:0]}.
p_gnt  out  4  one-hot grant pulse, one cycle; sampled p_pos is consumed.
plot  out  1  one-cycle write strobe to vga_adapter.
x  out  8  pixel x.
y  out  7  pixel y.
colour  out  3  pixel colour.
running  out  1  game active.
timer_x  out  8  next bar column to draw.

Behaviour:
- Reset (async, resetn=0):
  - p_gnt=0, plot=0, x=0, y=0, colour=0.
  - running=0, timer_x=0, timer_pend=0.
  - rr_ptr=0 (slot 0 is first in search order).
- start=1 (any state, including mid-round):
  - Next cycle: running=1, timer_x=0, timer_pend=0, rr_ptr=0.
  - No grant is issued in the start cycle.
- tick_en=1 while running=1 and timer_pend=0 sets timer_pend=1. A tick while pending is dropped; no queueing.
- Eligible slots each cycle:
  - Player i is eligible when p_req[i]=1 and running=1. When running=0, all p_req are ignored and p_gnt stays 0.
  - Slot 4 is eligible when timer_pend=1.
- Arbitration:
  - Search order starts at rr_ptr and wraps mod 5.
  - The first eligible slot g is granted. Then rr_ptr <= (g+1) mod 5.
  - At most one grant per cycle; no eligible slot means no grant, and rr_ptr holds.
- Player grant (g<4):
  - p_gnt[g]=1 combinationally in cycle N.
  - The requester may drop or change p_req/p_pos from cycle N+1.
- Output latency:
  - A grant in cycle N gives plot=1 in cycle N+1.
  - x, y and colour are registered from the slot sampled in cycle N.
  - Colours: player0=001, player1=010, player2=100, player3=110, timer=111.
- Timer grant:
  - Outputs x=timer_x, y=TIMER_ROW; timer_pend clears.
  - If timer_x==TIMER_LAST_X: running <= 0 in the same edge, and timer_x holds at TIMER_LAST_X. Otherwise timer_x <= timer_x+1.
- Pending timer slot after the round ends: a timer_pend still set when running falls is still granted and plotted.
- Idle: plot=0 when nothing was granted the previous cycle; x, y and colour hold their last values.
- Simultaneous start with tick_en: start wins and the tick is dropped.
- Simultaneous start with a grant: no grant that cycle.
- Fairness bound: a continuously requesting slot is granted within 5 cycles.

Decomposition:
- Shared package: slot index constants (SLOT_P0..SLOT_P3=0..3, SLOT_TIMER=4), the colour constants per slot, and the packed-position field widths (X_W=8, Y_W=7, POS_W=15).
- One natural sub-module, rr_arbiter5:
  - Inputs: 5-bit eligible vector and 3-bit pointer.
  - Outputs: one-hot grant, grant index and next pointer.
  - Purely combinational; the top level holds the pointer register and the timer/running state.

Test Plan:
- Reset and idle:
  - Stimulus: assert resetn=0 mid-operation, then release it.
  - Required: all outputs 0; no plot and no grant until start.
- Round-robin:
  - Stimulus: start, then hold p_req=4'b1111 with distinct p_pos.
  - Required: grants 0,1,2,3 on consecutive cycles, repeating; each plot follows one cycle later with the matching x, y and colour (001, 010, 100, 110).
- Timer interleave:
  - Stimulus: p_req=4'b1111 with one tick_en pulse.
  - Required: slot 4 is granted within 5 cycles; plot at (0,119), colour 111; timer_x becomes 1.
- Dropped tick:
  - Stimulus: two tick_en pulses before the timer is granted.
  - Required: only one bar pixel is plotted; timer_x advances by exactly 1.
- End of round:
  - Stimulus: 159 spaced tick_en pulses.
  - Required: the final bar plot is at x=158; running falls the cycle of that grant; later p_req gets no grant; timer_x stays 158.
- Restart:
  - Stimulus: pulse start when running=0, and also mid-round with timer_x=40 and timer_pend=1.
  - Required: running=1, timer_x=0, pending tick cleared, rr_ptr=0, so the next grant goes to the lowest requesting player.
